sar_search_ctrl: RTL

//  Successive-approximation search controller; the initiator side of a magnitude comparator.

---
 rtl/sar_pkg.sv | 20 ++
 rtl/sar_search_ctrl_if.sv | 32 +++
 rtl/sar_bounds_update.sv | 42 ++++
 rtl/sar_search_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
// State encoding plus the one-hot {gt,lt,eq} comparator flag constants.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      WAIT,
      DONE
   } sar_state_e;

   localparam logic [2:0] CMP_GT = 3'b100;
   localparam logic [2:0] CMP_LT = 3'b010;
   localparam logic [2:0] CMP_EQ = 3'b001;

   function automatic logic flags_onehot(input logic [2:0] f);
      return (f == CMP_GT) || (f == CMP_LT) || (f == CMP_EQ);
   endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Probe/compare handshake between the search controller and a comparator.
// master = controller (drives probes), slave = comparator (returns flags).
interface sar_search_ctrl_if #(
   parameter int WIDTH = 2
);

   logic             probe_valid;
   logic [WIDTH-1:0] probe;
   logic             cmp_valid;
   logic             cmp_gt;
   logic             cmp_lt;
   logic             cmp_eq;

   modport master (
      output probe_valid,
      output probe,
      input  cmp_valid,
      input  cmp_gt,
      input  cmp_lt,
      input  cmp_eq
   );

   modport slave (
      input  probe_valid,
      input  probe,
      output cmp_valid,
      output cmp_gt,
      output cmp_lt,
      output cmp_eq
   );

endinterface

// File: rtl/sar_bounds_update.sv
// Combinational bound narrowing for one comparator answer.
// Priority eq > gt > lt; no flag set is handled as lt.
module sar_bounds_update
   import sar_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH:0]   lo_i,
   input  logic [WIDTH:0]   hi_i,
   input  logic [WIDTH-1:0] probe_i,
   input  logic [2:0]       flags_i,
   output logic [WIDTH:0]   lo_o,
   output logic [WIDTH:0]   hi_o,
   output logic             empty_o,
   output logic             hit_o
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] p_w;
   logic           go_up;

   assign p_w   = {1'b0, probe_i};
   assign hit_o = |(flags_i & CMP_EQ);
   assign go_up = |(flags_i & CMP_GT) && !hit_o;

   // Emptiness is judged against the probe itself, so the interval
   // check never depends on a decremented bound below zero.
   always_comb begin
      lo_o    = lo_i;
      hi_o    = hi_i;
      empty_o = 1'b0;
      if (go_up) begin
         lo_o    = p_w + ONE;
         empty_o = (p_w >= hi_i);
      end else if (!hit_o) begin
         hi_o    = p_w - ONE;
         empty_o = (p_w <= lo_i);
      end
   end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller (comparator initiator).
// Optional flag checking: define SAR_CMP_CHECK_EN to build the cmp_err logic.
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   sar_search_ctrl_if.master   cmp,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [WIDTH-1:0]    result,
   output logic [CNT_W-1:0]    probe_cnt,
   output logic                cmp_err
);

   localparam logic [WIDTH:0]   HI_RST  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   sar_state_e       state_q;
   logic [WIDTH:0]   lo_q, hi_q;
   logic [WIDTH:0]   lo_d, hi_d, mid_d;
   logic [WIDTH-1:0] probe_q, result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pv_q, busy_q, done_q, found_q;
   logic [2:0]       flags;
   logic             hs, empty, hit;

   assign flags = {cmp.cmp_gt, cmp.cmp_lt, cmp.cmp_eq};
   assign hs    = pv_q && cmp.cmp_valid && (state_q == WAIT);
   assign mid_d = lo_q + ((hi_q - lo_q) >> 1);

   sar_bounds_update #(
      .WIDTH (WIDTH)
   ) u_bounds (
      .lo_i    (lo_q),
      .hi_i    (hi_q),
      .probe_i (probe_q),
      .flags_i (flags),
      .lo_o    (lo_d),
      .hi_o    (hi_d),
      .empty_o (empty),
      .hit_o   (hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lo_q     <= '0;
         hi_q     <= HI_RST;
         probe_q  <= '0;
         pv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= PROBE;
                  busy_q   <= 1'b1;
                  found_q  <= 1'b0;
                  result_q <= '0;
                  cnt_q    <= '0;
                  lo_q     <= '0;
                  hi_q     <= HI_RST;
               end
            end
            PROBE: begin
               probe_q <= mid_d[WIDTH-1:0];
               pv_q    <= 1'b1;
               state_q <= WAIT;
            end
            WAIT: begin
               if (hs) begin
                  cnt_q <= cnt_q + CNT_ONE;
                  pv_q  <= 1'b0;
                  if (hit) begin
                     result_q <= probe_q;
                     found_q  <= 1'b1;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     lo_q <= lo_d;
                     hi_q <= hi_d;
                     if (empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        state_q <= PROBE;
                     end
                  end
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SAR_CMP_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (hs && !flags_onehot(flags)) begin
         err_q <= 1'b1;
      end
   end

   assign cmp_err = err_q;
`else
   assign cmp_err = 1'b0;
`endif

   assign cmp.probe_valid = pv_q;
   assign cmp.probe       = probe_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign found           = found_q;
   assign result          = result_q;
   assign probe_cnt       = cnt_q;

endmodule
